// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: line/frame measurement, lock FSM, active-pixel capture
// Optional frame CRC-16-CCITT over captured pixels when VGA_RX_CRC_EN is defined.
module vga_sync_rx #(
    parameter int CD          = 12,
    parameter int HT          = 800,
    parameter int VT          = 525,
    parameter int HACT_OFS    = 144,
    parameter int VACT_OFS    = 34,
    parameter int LOCK_FRAMES = 2,
    parameter int HACT        = 640,
    parameter int VACT        = 480
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_tick,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [CD-1:0] rgb,
    output logic          pix_valid,
    output logic [10:0]   pix_x,
    output logic [10:0]   pix_y,
    output logic [CD-1:0] pix_rgb,
    output logic          locked,
    output logic          frame_start,
    output logic [10:0]   line_len,
    output logic [10:0]   frame_lines,
    output logic          err_hlen,
    output logic          err_vlen,
    input  logic          err_clr
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0]   frame_crc,
    output logic          crc_valid
`endif
);

    localparam logic [10:0] HT_L    = 11'(HT);
    localparam logic [10:0] VT_L    = 11'(VT);
    localparam logic [10:0] H_LO    = 11'(HACT_OFS);
    localparam logic [10:0] H_HI    = 11'(HACT_OFS + HACT);
    localparam logic [10:0] V_LO    = 11'(VACT_OFS);
    localparam logic [10:0] V_HI    = 11'(VACT_OFS + VACT);
    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] CNT_PRE = 11'd2046;
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  good_q;
    logic        locked_q;

    logic        hs_q, hs_d, vs_q, vs_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic        frame_arm_q, frame_arm_d;
    logic        line_base_q, line_base_d, frame_base_q, frame_base_d;
    logic        frame_start_q, frame_start_d;
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [CD-1:0] pix_rgb_q, pix_rgb_d;
    logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;

    logic        hs_fall, arm_now, bad_line, bad_frame, bad_any, in_win;

    always_comb begin
        hs_d          = hs_q;
        vs_d          = vs_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        frame_arm_d   = frame_arm_q;
        line_base_d   = line_base_q;
        frame_base_d  = frame_base_q;
        frame_start_d = 1'b0;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_rgb_d     = pix_rgb_q;
        err_hlen_d    = err_hlen_q;
        err_vlen_d    = err_vlen_q;
        bad_line      = 1'b0;
        bad_frame     = 1'b0;

        hs_fall = pix_tick & hs_q & ~hsync;
        // A vsync fall on the same tick as an hsync fall arms that very fall.
        arm_now = frame_arm_q | (pix_tick & vs_q & ~vsync);

        if (pix_tick) begin
            hs_d = hsync;
            vs_d = vsync;
            if (hs_fall) begin
                hcnt_d     = 11'd0;
                line_len_d = hcnt_q + 11'd1;
                bad_line   = line_base_q && (line_len_d != HT_L);
                frame_arm_d = 1'b0;
                if (arm_now) begin
                    vcnt_d        = 11'd0;
                    frame_lines_d = vcnt_q + 11'd1;
                    frame_start_d = 1'b1;
                    bad_frame     = frame_base_q && (frame_lines_d != VT_L);
                end else begin
                    if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 11'd1;
                    bad_frame = (vcnt_q == CNT_PRE);
                end
            end else begin
                frame_arm_d = arm_now;
                if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;
                bad_line = (hcnt_q == CNT_PRE);
            end
        end

        bad_any = bad_line | bad_frame;

        // Any error restarts the baseline so the next measurement is not judged.
        if (bad_any) begin
            line_base_d  = 1'b0;
            frame_base_d = 1'b0;
        end else begin
            if (hs_fall)       line_base_d  = 1'b1;
            if (frame_start_d) frame_base_d = 1'b1;
        end

        in_win = (hcnt_d >= H_LO) && (hcnt_d < H_HI) && (vcnt_d >= V_LO) && (vcnt_d < V_HI);
        if (pix_tick && (state_q == S_LOCKED) && !bad_any && in_win) begin
            pix_valid_d = 1'b1;
            pix_x_d     = hcnt_d - H_LO;
            pix_y_d     = vcnt_d - V_LO;
            pix_rgb_d   = rgb;
        end

        if (bad_line)     err_hlen_d = 1'b1;
        else if (err_clr) err_hlen_d = 1'b0;
        if (bad_frame)    err_vlen_d = 1'b1;
        else if (err_clr) err_vlen_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hcnt_q        <= 11'd0;
            vcnt_q        <= 11'd0;
            line_len_q    <= 11'd0;
            frame_lines_q <= 11'd0;
            frame_arm_q   <= 1'b0;
            line_base_q   <= 1'b0;
            frame_base_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 11'd0;
            pix_y_q       <= 11'd0;
            pix_rgb_q     <= '0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
        end else begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_arm_q   <= frame_arm_d;
            line_base_q   <= line_base_d;
            frame_base_q  <= frame_base_d;
            frame_start_q <= frame_start_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            err_hlen_q    <= err_hlen_d;
            err_vlen_q    <= err_vlen_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_UNLOCK;
            good_q   <= 8'd0;
            locked_q <= 1'b0;
        end else if (bad_any) begin
            state_q  <= S_UNLOCK;
            good_q   <= 8'd0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                S_UNLOCK: begin
                    if (frame_start_d) begin
                        state_q <= S_TRACK;
                        good_q  <= 8'd0;
                    end
                end
                S_TRACK: begin
                    if (frame_start_d) begin
                        good_q <= good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_N) begin
                            state_q  <= S_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_UNLOCK;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign err_hlen    = err_hlen_q;
    assign err_vlen    = err_vlen_q;

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [CD-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = CD - 1; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc_run_q, crc_run_d, crc_acc;
    logic [15:0] frame_crc_q, frame_crc_d;
    logic        crc_valid_q, crc_valid_d;

    // Latching on frame_start_d keeps crc_valid aligned with the frame_start pulse.
    always_comb begin
        crc_acc     = pix_valid_q ? crc_step(crc_run_q, pix_rgb_q) : crc_run_q;
        crc_run_d   = crc_acc;
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (frame_start_d) begin
            frame_crc_d = crc_acc;
            crc_run_d   = 16'hFFFF;
            crc_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_run_q   <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
            crc_valid_q <= 1'b0;
        end else begin
            crc_run_q   <= crc_run_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - self-checking bench for vga_sync_rx on a scaled-down raster
module tb_vga_sync_rx;

    localparam int CD   = 12;
    localparam int HT   = 40;
    localparam int VT   = 20;
    localparam int HOFS = 8;
    localparam int VOFS = 3;
    localparam int HACT = 24;
    localparam int VACT = 12;
    localparam int HSW  = 4;
    localparam int VSW  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_tick = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic [CD-1:0] rgb = '0;
    logic          err_clr = 1'b0;
    logic          pix_valid, locked, frame_start, err_hlen, err_vlen;
    logic [10:0]   pix_x, pix_y, line_len, frame_lines;
    logic [CD-1:0] pix_rgb;
`ifdef VGA_RX_CRC_EN
    logic [15:0]   frame_crc;
    logic          crc_valid;
`endif

    vga_sync_rx #(
        .CD(CD), .HT(HT), .VT(VT), .HACT_OFS(HOFS), .VACT_OFS(VOFS),
        .LOCK_FRAMES(2), .HACT(HACT), .VACT(VACT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .locked(locked), .frame_start(frame_start), .line_len(line_len),
        .frame_lines(frame_lines), .err_hlen(err_hlen), .err_vlen(err_vlen), .err_clr(err_clr)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    int gen_h = 0, gen_v = 0, short_v = -1;
    bit gen_run = 0, hs_hold = 0, const_rgb = 0;

    task automatic drive();
        hsync = hs_hold ? 1'b1 : (gen_h >= HSW);
        vsync = hs_hold ? 1'b1 : (gen_v >= VSW);
        if (gen_h >= HOFS && gen_h < HOFS + HACT && gen_v >= VOFS && gen_v < VOFS + VACT)
            rgb = const_rgb ? 12'hFFF : 12'(gen_h - HOFS);
        else
            rgb = '0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gen_run) begin
                if (pix_tick) begin
                    gen_h++;
                    if (gen_h >= ((gen_v == short_v) ? HT - 1 : HT)) begin
                        gen_h = 0;
                        gen_v = (gen_v == VT - 1) ? 0 : gen_v + 1;
                    end
                end
                pix_tick = ~pix_tick;
                drive();
            end
        end
    end

    int ex = 0, ey = 0, pcnt = 0, last_pix = 0, viol = 0;

    always @(negedge clk) begin
        if (frame_start) begin
            last_pix = pcnt;
            pcnt = 0;
            ex = 0;
            ey = 0;
        end
        if (pix_valid) begin
            check("pix_x", 32'(pix_x), 32'(ex));
            check("pix_y", 32'(pix_y), 32'(ey));
            check("pix_rgb", 32'(pix_rgb), const_rgb ? 32'hFFF : 32'(ex));
            if (!locked) viol++;
            pcnt++;
            ex++;
            if (ex == HACT) begin
                ex = 0;
                ey++;
            end
        end
    end

    task automatic wait_fs(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            @(negedge clk);
            while (!frame_start && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (!frame_start) begin
                checks++;
                $display("FAIL frame_start_timeout: got 0 expected 1");
            end
        end
    endtask

    task automatic wait_locked();
        int t = 0;
        while (!locked && t < 20000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_gen(input int v, input int h);
        int t = 0;
        @(negedge clk);
        while (!(gen_v == v && gen_h == h) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        check("gen_wait", 32'(gen_v == v && gen_h == h), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, 32'(pix_valid), 0);
        check({tag, "_pix_x"}, 32'(pix_x), 0);
        check({tag, "_pix_y"}, 32'(pix_y), 0);
        check({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
        check({tag, "_line_len"}, 32'(line_len), 0);
        check({tag, "_frame_lines"}, 32'(frame_lines), 0);
        check({tag, "_err_hlen"}, 32'(err_hlen), 0);
        check({tag, "_err_vlen"}, 32'(err_vlen), 0);
    endtask

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 11; b >= 0; b--) begin
            if (r[15] != d[b]) r = (r << 1) ^ 16'h1021;
            else r = r << 1;
        end
        return r;
    endfunction
`endif

    typedef struct {
        int          act;
        int          nfs;
        logic        lk;
        logic        eh;
        logic        ev;
        logic [10:0] ll;
        logic [10:0] fl;
        bit          cpix;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 1, 1'b0, 1'b0, 1'b0, 11'd1,  11'd1,  1'b0};
        tbl[1] = '{0, 1, 1'b0, 1'b0, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[2] = '{0, 1, 1'b1, 1'b0, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[3] = '{0, 1, 1'b1, 1'b0, 1'b0, 11'd40, 11'd20, 1'b1};
        tbl[4] = '{1, 1, 1'b0, 1'b1, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[5] = '{0, 1, 1'b0, 1'b1, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[6] = '{0, 1, 1'b1, 1'b1, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[7] = '{2, 0, 1'b1, 1'b0, 1'b0, 11'd40, 11'd20, 1'b0};
        tbl[8] = '{0, 1, 1'b1, 1'b0, 1'b0, 11'd40, 11'd20, 1'b1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle");
        gen_run = 1;

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].act == 1) begin
                int t = 0;
                short_v = 5;
                while (!err_hlen && t < 4000) begin
                    @(negedge clk);
                    t++;
                end
                check("short_err_hlen", 32'(err_hlen), 1);
                check("short_locked", 32'(locked), 0);
                check("short_line_len", 32'(line_len), HT - 1);
                short_v = -1;
            end else if (tbl[i].act == 2) begin
                @(posedge clk);
                #1 err_clr = 1'b1;
                @(posedge clk);
                #1 err_clr = 1'b0;
            end
            wait_fs(tbl[i].nfs);
            @(negedge clk);
            check($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            check($sformatf("v%0d_err_hlen", i), 32'(err_hlen), 32'(tbl[i].eh));
            check($sformatf("v%0d_err_vlen", i), 32'(err_vlen), 32'(tbl[i].ev));
            check($sformatf("v%0d_line_len", i), 32'(line_len), 32'(tbl[i].ll));
            check($sformatf("v%0d_frame_lines", i), 32'(frame_lines), 32'(tbl[i].fl));
            if (tbl[i].cpix) check($sformatf("v%0d_pix_count", i), 32'(last_pix), HACT * VACT);
        end

        // Sync hold: hcnt must saturate and drop lock.
        wait_gen(10, 10);
        hs_hold = 1;
        repeat (4200) @(negedge clk);
        check("hold_hcnt", 32'(dut.hcnt_q), 32'd2047);
        check("hold_err_hlen", 32'(err_hlen), 1);
        check("hold_locked", 32'(locked), 0);
        check("hold_state", 32'(dut.state_q), 0);
        wait_gen(10, 10);
        hs_hold = 0;
        wait_locked();
        check("hold_relock", 32'(locked), 1);
        check("hold_err_vlen", 32'(err_vlen), 0);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("hold_err_clr", 32'(err_hlen), 0);

        // Asynchronous reset mid-line.
        wait_fs(1);
        wait_gen(5, 20);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_locked();
        check("rst_relock", 32'(locked), 1);
        check("rst_err_hlen", 32'(err_hlen), 0);
        check("rst_err_vlen", 32'(err_vlen), 0);

`ifdef VGA_RX_CRC_EN
        begin
            logic [15:0] exp_crc;
            exp_crc = 16'hFFFF;
            for (int n = 0; n < HACT * VACT; n++) exp_crc = crc12(exp_crc, 12'hFFF);
            wait_fs(1);
            const_rgb = 1;
            for (int f = 0; f < 2; f++) begin
                wait_fs(1);
                check($sformatf("crc_valid_%0d", f), 32'(crc_valid), 1);
                check($sformatf("frame_crc_%0d", f), 32'(frame_crc), 32'(exp_crc));
            end
            const_rgb = 0;
        end
`endif

        check("no_pix_while_unlocked", 32'(viol), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 SHALL have parameters: CD, 12, colour depth; HT, 800, expected pixel ticks per line; VT, 525, expected lines per frame; HACT_OFS, 144, ticks from hsync fall to first active pixel; VACT_OFS, 34, lines from frame origin to first active line; LOCK_FRAMES, 2, consecutive good frames to lock.
REQ-002 SHALL have ports: clk  in  1  system clock, single clock domain.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: pix_tick  in  1  pixel enable, one clk wide, typically every 2nd clk (25 MHz).
REQ-005 SHALL have ports: hsync, vsync  in  1 each  active-low sync from a 640x480 source.
REQ-006 SHALL have ports: rgb  in  CD  pixel data.
REQ-007 SHALL have ports: pix_valid  out  1  pulse, active pixel captured; pix_x, pix_y  out  11 each  pixel coordinate; pix_rgb  out  CD  pixel data.
REQ-008 SHALL have ports: locked  out  1; frame_start  out  1  one-clk pulse; line_len, frame_lines  out  11 each  last measured values; err_hlen, err_vlen  out  1 each  sticky errors; err_clr  in  1  clears sticky errors.

Function
REQ-009 SHALL sample hsync, vsync and rgb only on clk edges where pix_tick=1; no other state advances without pix_tick, except err_clr handling and one-clk pulse deassertion.
REQ-010 SHALL detect a hsync fall when the previous sampled hsync=1 and the current sample=0; on that tick hcnt<=0, line_len<=hcnt+1, otherwise hcnt increments, saturating at 2047.
REQ-011 SHALL arm a frame flag on a vsync fall; the next hsync fall sets vcnt<=0, frame_lines<=vcnt+1 and pulses frame_start; other hsync falls increment vcnt, saturating at 2047.
REQ-012 SHALL, when hsync and vsync fall on the same tick, treat the frame flag as armed for that hsync fall.
REQ-013 SHALL flag a bad line when line_len is updated to a value other than HT, or when hcnt reaches 2047; it SHALL flag a bad frame when frame_lines is updated to a value other than VT, or when vcnt reaches 2047.
REQ-014 SHALL ignore the first line and first frame measured after reset or after unlock for error purposes; their counts start the baseline only.
REQ-015 SHALL set err_hlen on a bad line and err_vlen on a bad frame, both sticky; err_clr=1 clears them the next clk, and a simultaneous new error SHALL win.
REQ-016 SHALL run an FSM with states UNLOCK, TRACK and LOCKED; locked=1 only in LOCKED.
REQ-017 SHALL move UNLOCK->TRACK on the first frame_start and clear the good-frame count.
REQ-018 SHALL, in TRACK, increment the good-frame count at each frame_start that closes a frame with no bad line, and move TRACK->LOCKED when the count reaches LOCK_FRAMES.
REQ-019 SHALL move TRACK or LOCKED ->UNLOCK on any bad line or bad frame, in the same clk it is detected.
REQ-020 SHALL, in LOCKED on a tick where HACT_OFS<=hcnt<HACT_OFS+640 and VACT_OFS<=vcnt<VACT_OFS+480 (post-update values), on the following clk drive pix_valid=1 for one clk, with pix_x=hcnt-HACT_OFS, pix_y=vcnt-VACT_OFS and pix_rgb=the sampled rgb.
REQ-021 SHALL use 11-bit unsigned arithmetic throughout; offsets are applied only inside the window, so there is no negative wrap.

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force: FSM to UNLOCK; hcnt, vcnt, line_len, frame_lines, pix_x, pix_y and pix_rgb to 0; pix_valid, locked, frame_start, err_hlen, err_vlen and the frame flag to 0; sampled hsync and vsync to 1.
REQ-023 SHALL, after reset deasserts mid-frame, resynchronise from the next hsync and vsync edges per REQ-010 to REQ-019.

Configuration
REQ-024 SHALL compile frame CRC support only when macro VGA_RX_CRC_EN is defined: ports frame_crc (out, 16) and crc_valid (out, 1).
REQ-025 SHALL, with VGA_RX_CRC_EN defined, compute CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, MSB first) over the CD bits of each pix_valid pixel; at frame_start, frame_crc<=the running CRC, crc_valid pulses for one clk, and the running CRC re-inits. Both outputs SHALL reset to 0.
REQ-026 SHALL, without VGA_RX_CRC_EN, omit those ports and all CRC logic.

Verification
REQ-027 SHALL cover: the team's 640x480 sync generator with pix_tick every 2nd clk for 3 frames -> locked=1 after the 2nd frame_start following the first; line_len=800; frame_lines=525; no errors.
REQ-028 SHALL cover: a locked stream with rgb=pix_x[11:0] -> pix_valid 307200 times per frame; pix_x 0..639; pix_y 0..479; pix_rgb==pix_x at every pulse.
REQ-029 SHALL cover: one line shortened to 799 ticks while locked -> err_hlen=1 and locked=0 at that hsync fall; relock after 2 clean frames; err_clr -> err_hlen=0.
REQ-030 SHALL cover: hsync held high for 2100 ticks -> hcnt saturates at 2047; err_hlen=1; FSM UNLOCK.
REQ-031 SHALL cover: reset_n pulsed low mid-line -> all outputs 0 immediately and no pix_valid until relock.
REQ-032 SHALL cover, with VGA_RX_CRC_EN: constant rgb=0xFFF frame -> identical frame_crc on consecutive frames and crc_valid with each frame_start.
